retire_commit_unit: RTL and testbench
=====================================

Name: retire_commit_unit

Overview:
- Parametrised in-order retire stage.
- Commits up to RETIRE_WIDTH completed ROB head entries per cycle and owns the architectural map table as internal state.
- Returns freed physical registers to the free list and raises a registered branch-recovery pulse.
- Buffers retired stores in a committed-store FIFO that drains to the memory port under a valid/ready handshake. Supports a halt-then-drain mode.

Parameters:
RETIRE_WIDTH, 3, max instructions retired per cycle (1..8)
N_ARCH_REG, 32, architectural registers
N_PHYS_REG_BITS, 6, physical register index width
XLEN, 32, data/address width
SB_DEPTH, 4, committed-store buffer entries (power of 2, >=2)

Ports:
clock  input  1  system clock
reset  input  1  synchronous active-high reset
rob_valid  input  RETIRE_WIDTH  head slot i holds an entry
rob_complete  input  RETIRE_WIDTH  slot i executed
rob_halt  input  RETIRE_WIDTH  slot i is a halt/wfi
rob_mispred  input  RETIRE_WIDTH  slot i is a mispredicted branch
rob_is_store  input  RETIRE_WIDTH  slot i is a store
rob_ar_idx  input  RETIRE_WIDTH*5  destination arch reg per slot
rob_t_idx  input  RETIRE_WIDTH*N_PHYS_REG_BITS  new physical tag
rob_told_idx  input  RETIRE_WIDTH*N_PHYS_REG_BITS  previous tag to free
rob_target_pc  input  RETIRE_WIDTH*XLEN  correct next PC for slot i
rob_st_addr  input  RETIRE_WIDTH*XLEN  store address
rob_st_data  input  RETIRE_WIDTH*XLEN  store data
mem_st_ready  input  1  memory accepts a store this cycle
retire_count  output  $clog2(RETIRE_WIDTH+1)  entries retired this cycle (ROB head advance)
free_valid  output  RETIRE_WIDTH  slot i returns rob_told_idx[i] to the free list
arch_map  output  N_ARCH_REG*N_PHYS_REG_BITS  registered architectural map table
recover_en  output  1  one-cycle registered recovery pulse
recover_pc  output  XLEN  fetch redirect PC, valid with recover_en
mem_st_valid  output  1  store buffer head is valid
mem_st_addr  output  XLEN  head store address
mem_st_data  output  XLEN  head store data
halted  output  1  sticky: a halt has retired
halt_done  output  1  halted and store buffer empty

Behaviour:
Reset (synchronous, active-high):
- arch_map[i] = i.
- Store buffer empty: head, tail and count = 0.
- recover_en = 0, recover_pc = 0, halted = 0.
- Combinational outputs are 0 while reset is high.
- A reset asserted mid-drain discards all buffered stores.

Retire enable (combinational, same cycle):
- en[0] = rob_valid[0] & rob_complete[0] & ~halted & ~recover_en & store_ok[0].
- en[i] = en[i-1] & rob_valid[i] & rob_complete[i] & ~rob_mispred[i-1] & ~rob_halt[i-1] & store_ok[i].
- store_ok[i]: the number of stores in slots 0..i is <= SB_DEPTH - count, using the registered count. A pop in the same cycle does not free a slot until the next cycle.
- retire_count = popcount(en); en is always a prefix.
- free_valid[i] = en[i].

Map update (registered):
- For each enabled slot with rob_ar_idx != 0, arch_map[ar] <= t_idx.
- When slots write the same ar, the highest slot wins.
- x0 is never remapped.

Recovery:
- If en[i] & rob_mispred[i], then next cycle recover_en = 1 and recover_pc = rob_target_pc[i].
- The pulse lasts exactly one cycle.
- No retire occurs during the pulse cycle.
- The mispredicted slot itself retires, including its map write and store push.

Halt:
- If en[i] & rob_halt[i], halted <= 1 next cycle.
- Later slots do not retire; halted stays set until reset.
- halt_done = halted & (count == 0).

Store buffer:
- Enabled store slots push in slot order at tail.
- Head drains when mem_st_valid & mem_st_ready. mem_st_valid = (count != 0).
- Head fields are held stable until accepted.
- Pointers wrap modulo SB_DEPTH; count is updated as count + pushes - pop.
- When full, no store retires and younger slots also stall, even non-stores.
- Draining continues while halted.

Test Plan:
- All 3 slots complete, ar = 5, 6, 5 with t = 40, 41, 42 -> retire_count = 3; next cycle arch_map[5] = 42 and arch_map[6] = 41; free_valid = 3'b111.
- Slot0 complete, slot1 incomplete, slot2 complete -> retire_count = 1 and free_valid = 3'b001.
- Slot1 mispred with target_pc 0x0000_1040, slot2 complete -> retire_count = 2; next cycle recover_en = 1 and recover_pc = 0x1040, retire_count = 0; the cycle after, recover_en = 0.
- SB_DEPTH = 4, mem_st_ready = 0, 5 stores offered over 2 cycles -> 4 accepted and the 5th stalls. Raise ready for one cycle -> head (first store's addr/data) pops; the 5th store retires the following cycle; wrap-around order is preserved.
- Slot0 halt while 2 stores are buffered -> halted = 1 and halt_done = 0. With ready held high, halt_done = 1 after 2 pops; no further retires.
- Reset asserted with 3 stores buffered -> next cycle mem_st_valid = 0, arch_map is identity, and halted = 0.

Source files
------------

// File: rtl/retire_commit_unit_if.sv
// Committed-store memory port: the retire unit presents its store-buffer head,
// memory accepts it with mem_st_ready.
interface retire_commit_unit_if #(
  parameter int XLEN = 32
) ();
  logic            mem_st_valid;
  logic            mem_st_ready;
  logic [XLEN-1:0] mem_st_addr;
  logic [XLEN-1:0] mem_st_data;

  modport master (output mem_st_valid, output mem_st_addr, output mem_st_data,
                  input  mem_st_ready);
  modport slave  (input  mem_st_valid, input  mem_st_addr, input  mem_st_data,
                  output mem_st_ready);
endinterface

// File: rtl/retire_commit_unit.sv
// In-order retire stage: commits a prefix of completed ROB head slots, owns the
// architectural map, raises branch recovery and buffers committed stores.
module retire_commit_unit #(
  parameter int RETIRE_WIDTH    = 3,
  parameter int N_ARCH_REG      = 32,
  parameter int N_PHYS_REG_BITS = 6,
  parameter int XLEN            = 32,
  parameter int SB_DEPTH        = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [RETIRE_WIDTH-1:0]                  rob_valid,
  input  logic [RETIRE_WIDTH-1:0]                  rob_complete,
  input  logic [RETIRE_WIDTH-1:0]                  rob_halt,
  input  logic [RETIRE_WIDTH-1:0]                  rob_mispred,
  input  logic [RETIRE_WIDTH-1:0]                  rob_is_store,
  input  logic [RETIRE_WIDTH*5-1:0]                rob_ar_idx,
  input  logic [RETIRE_WIDTH*N_PHYS_REG_BITS-1:0]  rob_t_idx,
  input  logic [RETIRE_WIDTH*N_PHYS_REG_BITS-1:0]  rob_told_idx,
  input  logic [RETIRE_WIDTH*XLEN-1:0]             rob_target_pc,
  input  logic [RETIRE_WIDTH*XLEN-1:0]             rob_st_addr,
  input  logic [RETIRE_WIDTH*XLEN-1:0]             rob_st_data,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]        retire_count,
  output logic [RETIRE_WIDTH-1:0]                  free_valid,
  output logic [N_ARCH_REG*N_PHYS_REG_BITS-1:0]    arch_map,
  output logic                                     recover_en,
  output logic [XLEN-1:0]                          recover_pc,
  retire_commit_unit_if.master                     mem_st,
  output logic                                     halted,
  output logic                                     halt_done
);

  localparam int CW = $clog2(RETIRE_WIDTH + 1);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int NW = $clog2(SB_DEPTH + 1);

  typedef logic [N_PHYS_REG_BITS-1:0] ptag_t;

  ptag_t           map_q     [N_ARCH_REG];
  logic [XLEN-1:0] sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0] sb_data_q [SB_DEPTH];

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [NW-1:0]   count_q, count_d;
  logic            recover_q, recover_d;
  logic [XLEN-1:0] recover_pc_q, recover_pc_d;
  logic            halted_q, halted_d;

  logic [RETIRE_WIDTH-1:0] en;
  logic [PW-1:0]           wr_idx [RETIRE_WIDTH];
  logic                    pop;
  logic                    chain;
  int unsigned             n_st, n_push, n_ret, room;

  // The free list consumes rob_told_idx directly, qualified by free_valid.
  logic unused_told;
  assign unused_told = ^rob_told_idx;

  always_comb begin
    en           = '0;
    n_st         = 0;
    n_push       = 0;
    n_ret        = 0;
    recover_d    = 1'b0;
    recover_pc_d = recover_pc_q;
    halted_d     = halted_q;
    pop          = ~reset & (count_q != '0) & mem_st.mem_st_ready;
    // Room comes from the registered count: a same-cycle pop is not reusable.
    room         = int'(SB_DEPTH) - int'(count_q);
    chain        = ~reset & ~halted_q & ~recover_q;
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      wr_idx[i] = '0;
    end
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      n_st      = n_st + 32'(rob_is_store[i]);
      wr_idx[i] = tail_q + PW'(n_push);
      en[i]     = chain & rob_valid[i] & rob_complete[i] & (n_st <= room);
      if (en[i]) n_ret = n_ret + 1;
      if (en[i] & rob_is_store[i]) n_push = n_push + 1;
      if (en[i] & rob_mispred[i]) begin
        recover_d    = 1'b1;
        recover_pc_d = rob_target_pc[i*XLEN +: XLEN];
      end
      if (en[i] & rob_halt[i]) halted_d = 1'b1;
      chain = en[i] & ~rob_mispred[i] & ~rob_halt[i];
    end
    retire_count = CW'(n_ret);
    free_valid   = en;
    tail_d       = tail_q + PW'(n_push);
    head_d       = head_q + PW'(pop);
    count_d      = count_q + NW'(n_push) - NW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      recover_q    <= 1'b0;
      recover_pc_q <= '0;
      halted_q     <= 1'b0;
      for (int unsigned a = 0; a < N_ARCH_REG; a++) begin
        map_q[a] <= ptag_t'(a);
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      recover_q    <= recover_d;
      recover_pc_q <= recover_pc_d;
      halted_q     <= halted_d;
      // Ascending slot order makes the youngest writer of an arch reg win.
      for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
        if (en[i] && rob_ar_idx[i*5 +: 5] != '0 && int'(rob_ar_idx[i*5 +: 5]) < N_ARCH_REG) begin
          map_q[rob_ar_idx[i*5 +: 5]] <= rob_t_idx[i*N_PHYS_REG_BITS +: N_PHYS_REG_BITS];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      if (en[i] & rob_is_store[i]) begin
        sb_addr_q[wr_idx[i]] <= rob_st_addr[i*XLEN +: XLEN];
        sb_data_q[wr_idx[i]] <= rob_st_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    arch_map = '0;
    for (int unsigned a = 0; a < N_ARCH_REG; a++) begin
      arch_map[a*N_PHYS_REG_BITS +: N_PHYS_REG_BITS] = map_q[a];
    end
  end

  assign recover_en          = recover_q;
  assign recover_pc          = recover_pc_q;
  assign halted              = halted_q;
  assign halt_done           = ~reset & halted_q & (count_q == '0);
  assign mem_st.mem_st_valid = ~reset & (count_q != '0);
  assign mem_st.mem_st_addr  = reset ? '0 : sb_addr_q[head_q];
  assign mem_st.mem_st_data  = reset ? '0 : sb_data_q[head_q];

endmodule

// File: tb/tb_retire_commit_unit.sv
// Directed bench for retire_commit_unit at default parameters.
module tb_retire_commit_unit;
  localparam int RW = 3;
  localparam int NA = 32;
  localparam int PB = 6;
  localparam int XL = 32;

  logic clock = 1'b0;
  logic reset;
  logic [RW-1:0]    rob_valid, rob_complete, rob_halt, rob_mispred, rob_is_store;
  logic [RW*5-1:0]  rob_ar_idx;
  logic [RW*PB-1:0] rob_t_idx, rob_told_idx;
  logic [RW*XL-1:0] rob_target_pc, rob_st_addr, rob_st_data;
  logic [1:0]       retire_count;
  logic [RW-1:0]    free_valid;
  logic [NA*PB-1:0] arch_map;
  logic             recover_en;
  logic [XL-1:0]    recover_pc;
  logic             halted, halt_done;
  logic [NA*PB-1:0] identity;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  retire_commit_unit_if #(.XLEN(XL)) mem_if ();

  retire_commit_unit #(
    .RETIRE_WIDTH(RW), .N_ARCH_REG(NA), .N_PHYS_REG_BITS(PB), .XLEN(XL), .SB_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .rob_valid(rob_valid), .rob_complete(rob_complete), .rob_halt(rob_halt),
    .rob_mispred(rob_mispred), .rob_is_store(rob_is_store), .rob_ar_idx(rob_ar_idx),
    .rob_t_idx(rob_t_idx), .rob_told_idx(rob_told_idx), .rob_target_pc(rob_target_pc),
    .rob_st_addr(rob_st_addr), .rob_st_data(rob_st_data),
    .retire_count(retire_count), .free_valid(free_valid), .arch_map(arch_map),
    .recover_en(recover_en), .recover_pc(recover_pc), .mem_st(mem_if),
    .halted(halted), .halt_done(halt_done)
  );

  always #5 clock = ~clock;

  function automatic logic [PB-1:0] map_of(input int a);
    return arch_map[a*PB +: PB];
  endfunction

  task automatic clear_rob();
    rob_valid = '0; rob_complete = '0; rob_halt = '0; rob_mispred = '0; rob_is_store = '0;
    rob_ar_idx = '0; rob_t_idx = '0; rob_told_idx = '0;
    rob_target_pc = '0; rob_st_addr = '0; rob_st_data = '0;
  endtask

  task automatic set_slot(input int i, input logic cmp, input logic hlt, input logic mp,
                          input logic st, input int ar, input int t, input logic [XL-1:0] pc,
                          input logic [XL-1:0] addr, input logic [XL-1:0] data);
    rob_valid[i] = 1'b1; rob_complete[i] = cmp; rob_halt[i] = hlt; rob_mispred[i] = mp;
    rob_is_store[i] = st;
    rob_ar_idx[i*5 +: 5] = 5'(ar);
    rob_t_idx[i*PB +: PB] = PB'(t);
    rob_told_idx[i*PB +: PB] = PB'(ar);
    rob_target_pc[i*XL +: XL] = pc;
    rob_st_addr[i*XL +: XL] = addr;
    rob_st_data[i*XL +: XL] = data;
  endtask

  task automatic step();
    @(posedge clock); #1;
    clear_rob();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < RW; i++) set_slot(i, 1'b1, 1'b0, 1'b0, 1'b0, i + 1, 20 + i, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd0) $display("FAIL rst_count got %0d want 0", retire_count); else n_pass++;
    n_total++; if (free_valid !== 3'b000) $display("FAIL rst_free got %b want 000", free_valid); else n_pass++;
    step();
    reset = 1'b0;
    n_total++; if (arch_map !== identity) $display("FAIL rst_map got %h want %h", arch_map, identity); else n_pass++;
    n_total++; if (mem_if.mem_st_valid !== 1'b0) $display("FAIL rst_stvalid got %b want 0", mem_if.mem_st_valid); else n_pass++;
    n_total++; if ({recover_en, halted, halt_done} !== 3'b000) $display("FAIL rst_flags got %b want 000", {recover_en, halted, halt_done}); else n_pass++;
    n_total++; if (recover_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", recover_pc); else n_pass++;
  endtask

  task automatic test_full_retire();
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 40, '0, '0, '0);
    set_slot(1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 41, '0, '0, '0);
    set_slot(2, 1'b1, 1'b0, 1'b0, 1'b0, 5, 42, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd3) $display("FAIL full_count got %0d want 3", retire_count); else n_pass++;
    n_total++; if (free_valid !== 3'b111) $display("FAIL full_free got %b want 111", free_valid); else n_pass++;
    step();
    n_total++; if (map_of(5) !== 6'd42) $display("FAIL full_map5 got %0d want 42", map_of(5)); else n_pass++;
    n_total++; if (map_of(6) !== 6'd41) $display("FAIL full_map6 got %0d want 41", map_of(6)); else n_pass++;
  endtask

  task automatic test_partial();
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 10, '0, '0, '0);
    set_slot(1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 11, '0, '0, '0);
    set_slot(2, 1'b1, 1'b0, 1'b0, 1'b0, 9, 12, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd1) $display("FAIL part_count got %0d want 1", retire_count); else n_pass++;
    n_total++; if (free_valid !== 3'b001) $display("FAIL part_free got %b want 001", free_valid); else n_pass++;
    step();
    n_total++; if ({map_of(7), map_of(9)} !== {6'd10, 6'd9}) $display("FAIL part_map got %0d/%0d want 10/9", map_of(7), map_of(9)); else n_pass++;
  endtask

  task automatic test_mispred();
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 11, '0, '0, '0);
    set_slot(1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 12, 32'h0000_1040, '0, '0);
    set_slot(2, 1'b1, 1'b0, 1'b0, 1'b0, 3, 13, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd2) $display("FAIL mp_count got %0d want 2", retire_count); else n_pass++;
    step();
    n_total++; if (recover_en !== 1'b1) $display("FAIL mp_pulse got %b want 1", recover_en); else n_pass++;
    n_total++; if (recover_pc !== 32'h0000_1040) $display("FAIL mp_pc got %h want 00001040", recover_pc); else n_pass++;
    n_total++; if ({map_of(2), map_of(3)} !== {6'd12, 6'd3}) $display("FAIL mp_map got %0d/%0d want 12/3", map_of(2), map_of(3)); else n_pass++;
    for (int i = 0; i < RW; i++) set_slot(i, 1'b1, 1'b0, 1'b0, 1'b0, 0, 50 + i, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd0) $display("FAIL mp_block got %0d want 0", retire_count); else n_pass++;
    step();
    n_total++; if (recover_en !== 1'b0) $display("FAIL mp_end got %b want 0", recover_en); else n_pass++;
    for (int i = 0; i < RW; i++) set_slot(i, 1'b1, 1'b0, 1'b0, 1'b0, 0, 50 + i, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd3) $display("FAIL mp_resume got %0d want 3", retire_count); else n_pass++;
    step();
    n_total++; if (map_of(0) !== 6'd0) $display("FAIL x0_map got %0d want 0", map_of(0)); else n_pass++;
  endtask

  task automatic test_store_fill();
    mem_if.mem_st_ready = 1'b0;
    for (int i = 0; i < RW; i++) set_slot(i, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h100 + i, 32'hA0 + i);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd3) $display("FAIL sb_first got %0d want 3", retire_count); else n_pass++;
    step();
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h103, 32'hA3);
    set_slot(1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h104, 32'hA4);
    set_slot(2, 1'b1, 1'b0, 1'b0, 1'b0, 9, 20, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd1) $display("FAIL sb_fill got %0d want 1", retire_count); else n_pass++;
    step();
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h104, 32'hA4);
    set_slot(1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 20, '0, '0, '0);
    mem_if.mem_st_ready = 1'b1;
    @(negedge clock);
    n_total++; if (retire_count !== 2'd0) $display("FAIL sb_full got %0d want 0", retire_count); else n_pass++;
    n_total++; if ({mem_if.mem_st_valid, mem_if.mem_st_addr, mem_if.mem_st_data} !== {1'b1, 32'h100, 32'hA0})
      $display("FAIL sb_head got %b/%h/%h want 1/00000100/000000a0", mem_if.mem_st_valid, mem_if.mem_st_addr, mem_if.mem_st_data); else n_pass++;
    step();
    mem_if.mem_st_ready = 1'b0;
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h104, 32'hA4);
    set_slot(1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 20, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd2) $display("FAIL sb_after_pop got %0d want 2", retire_count); else n_pass++;
    step();
    n_total++; if (map_of(9) !== 6'd20) $display("FAIL sb_map9 got %0d want 20", map_of(9)); else n_pass++;
    mem_if.mem_st_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      n_total++;
      if ({mem_if.mem_st_addr, mem_if.mem_st_data} !== {32'h100 + 32'(k), 32'hA0 + 32'(k)})
        $display("FAIL sb_drain%0d got %h/%h want %h/%h", k, mem_if.mem_st_addr, mem_if.mem_st_data, 32'h100 + k, 32'hA0 + k);
      else n_pass++;
      step();
    end
    @(negedge clock);
    n_total++; if (mem_if.mem_st_valid !== 1'b0) $display("FAIL sb_empty got %b want 0", mem_if.mem_st_valid); else n_pass++;
    step();
    mem_if.mem_st_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < RW; i++) set_slot(i, 1'b1, 1'b0, 1'b0, 1'b1, (i == 0) ? 4 : 0, 33, '0, 32'h180 + i, 32'hC0 + i);
    step();
    n_total++; if ({mem_if.mem_st_valid, map_of(4)} !== {1'b1, 6'd33}) $display("FAIL rd_pre got %b/%0d want 1/33", mem_if.mem_st_valid, map_of(4)); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if (mem_if.mem_st_valid !== 1'b0) $display("FAIL rd_valid got %b want 0", mem_if.mem_st_valid); else n_pass++;
    n_total++; if (arch_map !== identity) $display("FAIL rd_map got %h want %h", arch_map, identity); else n_pass++;
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h300, 32'hD0);
    step();
    n_total++; if (mem_if.mem_st_addr !== 32'h300) $display("FAIL rd_newhead got %h want 00000300", mem_if.mem_st_addr); else n_pass++;
    mem_if.mem_st_ready = 1'b1;
    step();
    mem_if.mem_st_ready = 1'b0;
  endtask

  task automatic test_halt();
    set_slot(0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h200, 32'hB0);
    set_slot(1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, '0, 32'h201, 32'hB1);
    step();
    set_slot(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, '0, '0, '0);
    set_slot(1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 30, '0, '0, '0);
    @(negedge clock);
    n_total++; if (retire_count !== 2'd1) $display("FAIL halt_count got %0d want 1", retire_count); else n_pass++;
    step();
    n_total++; if ({halted, halt_done} !== 2'b10) $display("FAIL halt_set got %b want 10", {halted, halt_done}); else n_pass++;
    n_total++; if (map_of(10) !== 6'd10) $display("FAIL halt_map10 got %0d want 10", map_of(10)); else n_pass++;
    mem_if.mem_st_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_slot(0, 1'b1, 1'b0, 1'b0, 1'b0, 11, 31, '0, '0, '0);
      @(negedge clock);
      n_total++; if (retire_count !== 2'd0) $display("FAIL halt_block%0d got %0d want 0", c, retire_count); else n_pass++;
      step();
    end
    n_total++; if ({halted, halt_done, mem_if.mem_st_valid} !== 3'b110) $display("FAIL halt_done got %b want 110", {halted, halt_done, mem_if.mem_st_valid}); else n_pass++;
    n_total++; if (map_of(11) !== 6'd11) $display("FAIL halt_map11 got %0d want 11", map_of(11)); else n_pass++;
    mem_if.mem_st_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if ({halted, halt_done} !== 2'b00) $display("FAIL halt_clear got %b want 00", {halted, halt_done}); else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < NA; a++) identity[a*PB +: PB] = PB'(a);
    reset = 1'b1;
    mem_if.mem_st_ready = 1'b0;
    clear_rob();
    test_reset();
    test_full_retire();
    test_partial();
    test_mispred();
    test_store_fill();
    test_reset_mid_drain();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
